wb_periph_arbiter: RTL and testbench

Two-master Wishbone B4 arbiter that shares the single slave port of the UART/SPI peripheral macro. Master 0 is the Caravel management SoC; master 1 is a user-side engine, such as a DMA or sequencer. It grants whole bus cycles (cyc-locked) with round-robin fairness and routes ack/data back only to the granted master.

---
 rtl/wb_periph_arbiter.sv | 169 ++++++++++++++++
 tb/tb_wb_periph_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_periph_arbiter.sv
// wb_periph_arbiter: two-master Wishbone B4 arbiter in front of the UART/SPI
// peripheral slave port. Master 0 is the management SoC, master 1 a user-side
// engine. Whole bus cycles are granted (locked on cyc), ties are broken
// round-robin, and ack/data are routed back only to the granted master.
//
// Optional feature: define WB_ARB_TIMEOUT_EN to enable the strobe timeout,
// which terminates a stalled strobe with ack and 32'hDEAD_BEEF and pulses
// timeout_o. Without it, timeout_o is tied low.

module wb_periph_arbiter #(
    parameter int TO_CYCLES = 255,
    parameter int TO_W      = 8
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    output logic [31:0] m0_dat_o,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    input  logic        m0_we_i,
    output logic        m0_ack_o,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    output logic [31:0] m1_dat_o,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    input  logic        m1_we_i,
    output logic        m1_ack_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    input  logic [31:0] s_dat_i,
    output logic [3:0]  s_sel_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    output logic        s_we_o,
    input  logic        s_ack_i,
    output logic [1:0]  gnt_o,
    output logic        timeout_o
);

    localparam logic [31:0] TO_DATA = 32'hDEAD_BEEF;

    // Reject configurations where the counter cannot reach the terminal count.
    if (TO_CYCLES < 2 || (64'd1 << TO_W) <= 64'(TO_CYCLES)) begin : g_bad_cfg
        $error("wb_periph_arbiter: TO_CYCLES must be >= 2 and below 2**TO_W");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t     state;
    logic       last_gnt;
    logic [1:0] gnt_q;
    logic       to_fire;

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);

    logic [TO_W-1:0] to_cnt;
    logic            own_stb;

    assign own_stb = (state == GNT0) ? m0_stb_i :
                     (state == GNT1) ? m1_stb_i : 1'b0;

    // A stalled strobe is cut off on its terminal cycle unless the slave
    // acknowledges in that very cycle.
    assign to_fire = own_stb && !s_ack_i && (to_cnt == TO_LAST);

    // Count consecutive unacknowledged strobe cycles of the granted master.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            to_cnt <= '0;
        end else if (state == IDLE || !own_stb || s_ack_i || to_fire) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    assign to_fire = 1'b0;
`endif

    assign timeout_o = to_fire;
    assign gnt_o     = gnt_q;

    // Arbitration FSM: grants are held for the whole cyc, with an IDLE cycle between grants.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            gnt_q    <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_cyc_i && (!m1_cyc_i || last_gnt)) begin
                        state    <= GNT0;
                        last_gnt <= 1'b0;
                        gnt_q    <= 2'b01;
                    end else if (m1_cyc_i) begin
                        state    <= GNT1;
                        last_gnt <= 1'b1;
                        gnt_q    <= 2'b10;
                    end
                end
                GNT0: begin
                    if (!m0_cyc_i) begin
                        state <= IDLE;
                        gnt_q <= 2'b00;
                    end
                end
                GNT1: begin
                    if (!m1_cyc_i) begin
                        state <= IDLE;
                        gnt_q <= 2'b00;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt_q <= 2'b00;
                end
            endcase
        end
    end

    // Route the granted master to the slave and the slave response back to it only.
    always_comb begin
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        s_we_o   = 1'b0;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        m0_ack_o = 1'b0;
        m0_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_dat_o = '0;
        case (state)
            GNT0: begin
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                s_we_o   = m0_we_i;
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i & ~to_fire;
                m0_ack_o = s_ack_i | to_fire;
                m0_dat_o = to_fire ? TO_DATA : s_dat_i;
            end
            GNT1: begin
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                s_we_o   = m1_we_i;
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i & ~to_fire;
                m1_ack_o = s_ack_i | to_fire;
                m1_dat_o = to_fire ? TO_DATA : s_dat_i;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_wb_periph_arbiter.sv
// Testbench for wb_periph_arbiter: directed steps followed by a randomized
// phase, all checked against a transaction-level reference model of the
// arbiter (owner, last winner, stall count).

module tb_wb_periph_arbiter;

    localparam int TO = 8;
`ifdef WB_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_adr, m0_wdat, m0_rdat, m1_adr, m1_wdat, m1_rdat;
    logic [3:0]  m0_sel, m1_sel;
    logic        m0_cyc, m0_stb, m0_we, m0_ack, m1_cyc, m1_stb, m1_we, m1_ack;
    logic [31:0] s_adr, s_wdat, s_rdat;
    logic [3:0]  s_sel;
    logic        s_cyc, s_stb, s_we, s_ack;
    logic [1:0]  gnt;
    logic        tmo;

    int checks = 0;
    int errors = 0;

    // Reference model: current owner (-1 none), last winner, stalled strobe cycles.
    int mown  = -1;
    int mlast = 1;
    int mcnt  = 0;

    always #5 clk = ~clk;

    wb_periph_arbiter #(.TO_CYCLES(TO), .TO_W(4)) dut (
        .wb_clk_i (clk),     .wb_rst_i (rst),
        .m0_adr_i (m0_adr),  .m0_dat_i (m0_wdat), .m0_dat_o (m0_rdat),
        .m0_sel_i (m0_sel),  .m0_cyc_i (m0_cyc),  .m0_stb_i (m0_stb),
        .m0_we_i  (m0_we),   .m0_ack_o (m0_ack),
        .m1_adr_i (m1_adr),  .m1_dat_i (m1_wdat), .m1_dat_o (m1_rdat),
        .m1_sel_i (m1_sel),  .m1_cyc_i (m1_cyc),  .m1_stb_i (m1_stb),
        .m1_we_i  (m1_we),   .m1_ack_o (m1_ack),
        .s_adr_o  (s_adr),   .s_dat_o  (s_wdat),  .s_dat_i  (s_rdat),
        .s_sel_o  (s_sel),   .s_cyc_o  (s_cyc),   .s_stb_o  (s_stb),
        .s_we_o   (s_we),    .s_ack_i  (s_ack),
        .gnt_o    (gnt),     .timeout_o (tmo)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic cyc_of(int o);
        return (o == 0) ? m0_cyc : m1_cyc;
    endfunction

    function automatic logic stb_of(int o);
        return (o == 0) ? m0_stb : m1_stb;
    endfunction

    function automatic logic fire_now();
        return TO_EN && (mown >= 0) && stb_of(mown) && !s_ack && (mcnt == TO - 1);
    endfunction

    // Compare every DUT output against what the model says for this cycle.
    task automatic check_all();
        logic        f, cyc, stb, we;
        logic [31:0] adr, wd;
        logic [3:0]  sel;
        logic [1:0]  eg;
        f = fire_now();
        cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; wd = '0; sel = '0; eg = 2'b00;
        if (mown == 0) begin
            cyc = m0_cyc; stb = m0_stb; we = m0_we; adr = m0_adr; wd = m0_wdat; sel = m0_sel; eg = 2'b01;
        end else if (mown == 1) begin
            cyc = m1_cyc; stb = m1_stb; we = m1_we; adr = m1_adr; wd = m1_wdat; sel = m1_sel; eg = 2'b10;
        end
        chk("gnt", {30'd0, gnt}, {30'd0, eg});
        chk("s_cyc", {31'd0, s_cyc}, {31'd0, cyc});
        chk("s_stb", {31'd0, s_stb}, {31'd0, stb & ~f});
        chk("s_adr", s_adr, adr);
        chk("s_dat", s_wdat, wd);
        chk("s_sel", {28'd0, s_sel}, {28'd0, sel});
        chk("s_we", {31'd0, s_we}, {31'd0, we});
        chk("m0_ack", {31'd0, m0_ack}, {31'd0, (mown == 0) && (s_ack || f)});
        chk("m0_dat", m0_rdat, (mown == 0) ? (f ? 32'hDEAD_BEEF : s_rdat) : 32'd0);
        chk("m1_ack", {31'd0, m1_ack}, {31'd0, (mown == 1) && (s_ack || f)});
        chk("m1_dat", m1_rdat, (mown == 1) ? (f ? 32'hDEAD_BEEF : s_rdat) : 32'd0);
        chk("timeout", {31'd0, tmo}, {31'd0, f});
    endtask

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_next();
        logic f;
        if (rst) begin
            mown = -1; mlast = 1; mcnt = 0;
        end else if (mown < 0) begin
            mcnt = 0;
            if (m0_cyc && m1_cyc) mown = 1 - mlast;
            else if (m0_cyc)      mown = 0;
            else if (m1_cyc)      mown = 1;
            if (mown >= 0) mlast = mown;
        end else begin
            f = fire_now();
            if (!cyc_of(mown)) begin
                mown = -1; mcnt = 0;
            end else if (stb_of(mown) && !s_ack && !f) begin
                mcnt++;
            end else begin
                mcnt = 0;
            end
        end
    endtask

    task automatic sample();
        #3;
        check_all();
    endtask

    task automatic advance();
        model_next();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_adr = '0; m0_wdat = '0; m0_sel = '0; m0_cyc = 0; m0_stb = 0; m0_we = 0;
        m1_adr = '0; m1_wdat = '0; m1_sel = '0; m1_cyc = 0; m1_stb = 0; m1_we = 0;
        s_rdat = '0; s_ack = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        advance();
        sample();
        chk("rst_gnt", {30'd0, gnt}, 32'd0);
        chk("rst_acks", {30'd0, m1_ack, m0_ack}, 32'd0);
        chk("rst_s_cyc", {31'd0, s_cyc}, 32'd0);
        chk("rst_timeout", {31'd0, tmo}, 32'd0);
        advance();
        rst = 1'b0;
    endtask

    initial begin
        logic [1:0] rr_seq [4];
        logic [1:0] rr_exp [4];
        int ngr, gcount, lat;

        rr_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
        rst = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        do_reset();

        // Single master read from m0 at 0x2004, slave acks after 3 cycles.
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h2004; m0_sel = 4'hF;
        sample();
        chk("sm_stb_before_gnt", {31'd0, s_stb}, 32'd0);
        advance();
        sample();
        chk("sm_stb_after_gnt", {31'd0, s_stb}, 32'd1);
        chk("sm_gnt", {30'd0, gnt}, 32'd1);
        chk("sm_adr", s_adr, 32'h2004);
        advance();
        repeat (2) begin
            sample();
            advance();
        end
        s_ack = 1; s_rdat = 32'h1234_5678;
        sample();
        chk("sm_ack", {31'd0, m0_ack}, 32'd1);
        chk("sm_rdata", m0_rdat, 32'h1234_5678);
        chk("sm_m1_ack", {31'd0, m1_ack}, 32'd0);
        advance();
        s_ack = 0; m0_cyc = 0; m0_stb = 0;
        sample();
        chk("sm_gnt_drop", {30'd0, gnt}, 32'd1);
        advance();
        sample();
        chk("sm_gnt_idle", {30'd0, gnt}, 32'd0);
        advance();

        // Tie and round-robin: both request continuously, each does one write per grant.
        do_reset();
        ngr = 0; gcount = 0;
        m0_we = 1; m1_we = 1; m0_wdat = 32'hA0A0_0000; m1_wdat = 32'hB1B1_0000;
        for (int i = 0; i < 40 && ngr < 4; i++) begin
            m0_stb = 0; m1_stb = 0; s_ack = 0;
            if (mown < 0) begin
                m0_cyc = 1; m1_cyc = 1; gcount = 0;
            end else if (gcount == 0) begin
                if (mown == 0) m0_stb = 1; else m1_stb = 1;
                s_ack = 1;
            end else begin
                if (mown == 0) m0_cyc = 0; else m1_cyc = 0;
            end
            sample();
            if (mown >= 0 && gcount == 0) begin
                rr_seq[ngr] = gnt;
                ngr++;
            end
            if (mown >= 0) gcount++;
            advance();
        end
        chk("rr_grants", ngr, 4);
        for (int k = 0; k < 4; k++) chk("rr_order", {30'd0, rr_seq[k]}, {30'd0, rr_exp[k]});
        idle_inputs();
        repeat (2) begin
            sample();
            advance();
        end

        // Lock: m1 holds cyc over three strobes while m0 keeps requesting.
        m1_cyc = 1; m1_adr = 32'h3000;
        sample();
        advance();
        m0_cyc = 1; m0_stb = 1;
        for (int k = 0; k < 6; k++) begin
            m1_stb = (k % 2 == 0); s_ack = (k % 2 == 0); s_rdat = 32'h100 + k;
            sample();
            chk("lock_gnt", {30'd0, gnt}, 32'd2);
            chk("lock_m0_ack", {31'd0, m0_ack}, 32'd0);
            advance();
        end
        m1_cyc = 0; m1_stb = 0; s_ack = 0;
        sample();
        chk("lock_release_hold", {30'd0, gnt}, 32'd2);
        advance();
        sample();
        chk("lock_idle_gap", {30'd0, gnt}, 32'd0);
        advance();
        sample();
        chk("lock_m0_gnt", {30'd0, gnt}, 32'd1);
        advance();
        idle_inputs();
        repeat (2) begin
            sample();
            advance();
        end

        // Abandon: m0 drops cyc before ack, the late ack lands in IDLE.
        m0_cyc = 1; m0_stb = 1;
        sample();
        advance();
        sample();
        advance();
        m0_cyc = 0; m0_stb = 0;
        sample();
        chk("ab_no_ack", {31'd0, m0_ack}, 32'd0);
        advance();
        s_ack = 1; s_rdat = 32'hCAFE_F00D;
        sample();
        chk("ab_late_m0_ack", {31'd0, m0_ack}, 32'd0);
        chk("ab_late_m1_ack", {31'd0, m1_ack}, 32'd0);
        chk("ab_gnt", {30'd0, gnt}, 32'd0);
        advance();
        s_ack = 0;

        // Reset in the middle of an m1 transfer.
        m1_cyc = 1; m1_stb = 1;
        sample();
        advance();
        sample();
        chk("rm_gnt", {30'd0, gnt}, 32'd2);
        advance();
        rst = 1; s_ack = 1; s_rdat = 32'h7777_7777;
        sample();
        advance();
        sample();
        chk("rm_gnt_after", {30'd0, gnt}, 32'd0);
        chk("rm_m1_ack", {31'd0, m1_ack}, 32'd0);
        rst = 0; m1_cyc = 0; m1_stb = 0; s_ack = 0;
        advance();

        // Stalled strobe on m0: slave never acknowledges.
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h2008;
        sample();
        advance();
`ifdef WB_ARB_TIMEOUT_EN
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            sample();
            if (lat == 0 && m0_ack === 1'b1) begin
                lat = k;
                chk("to_data", m0_rdat, 32'hDEAD_BEEF);
                chk("to_pulse", {31'd0, tmo}, 32'd1);
                chk("to_stb_cut", {31'd0, s_stb}, 32'd0);
            end
            advance();
            if (lat != 0) break;
        end
        chk("to_latency", lat, TO);
        m0_stb = 0;
        sample();
        chk("to_single_pulse", {31'd0, tmo}, 32'd0);
        advance();
        m0_stb = 1;
        for (int k = 1; k < TO; k++) begin
            sample();
            advance();
        end
        s_ack = 1; s_rdat = 32'h55AA_55AA;
        sample();
        chk("to_real_data", m0_rdat, 32'h55AA_55AA);
        chk("to_real_no_pulse", {31'd0, tmo}, 32'd0);
        advance();
        s_ack = 0;
`else
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            sample();
            if (m0_ack === 1'b1 || tmo === 1'b1) lat = k;
            advance();
        end
        chk("hang_no_ack_or_timeout", lat, 0);
`endif
        idle_inputs();
        repeat (2) begin
            sample();
            advance();
        end

        // Randomized traffic from both masters with a random slave.
        for (int i = 0; i < 1500; i++) begin
            if (m0_cyc) m0_cyc = ($urandom_range(0, 5) != 0);
            else        m0_cyc = ($urandom_range(0, 2) == 0);
            if (m1_cyc) m1_cyc = ($urandom_range(0, 5) != 0);
            else        m1_cyc = ($urandom_range(0, 2) == 0);
            m0_stb = m0_cyc && $urandom_range(0, 1);
            m1_stb = m1_cyc && $urandom_range(0, 1);
            m0_adr = $urandom; m0_wdat = $urandom; m0_sel = 4'($urandom); m0_we = 1'($urandom);
            m1_adr = $urandom; m1_wdat = $urandom; m1_sel = 4'($urandom); m1_we = 1'($urandom);
            s_rdat = $urandom;
            s_ack  = ($urandom_range(0, 2) == 0);
            rst    = ($urandom_range(0, 199) == 0);
            sample();
            advance();
        end
        rst = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
